obstacle_sequencer: RTL
=======================

// Module: obstacle_sequencer
// PURPOSE
//  Drives the 3-bit select of the 8:1 obstacle mux and starts each obstacle generator in turn.
//  Picks the next obstacle pseudo-randomly, never repeating the previous one.
//  Waits for that obstacle's done flag, or a frame-count timeout, then holds a blank gap and repeats.
//  Sits between game control (start/over) and the obstacle generators + obstacle mux.
// PARAMETERS
//  GAP_FRAMES      30     frames of blank (IDLE_SEL) between obstacles, >=1
//  TIMEOUT_FRAMES  600    max frames an obstacle may run before forced advance, >=2
//  LFSR_SEED       8'hA5  LFSR reset value, must be non-zero
//  IDLE_SEL        3'd0   mux slot wired to the "no obstacle" input
// PORTS
//  pclk            in   1  pixel clock; single clock domain
//  rst             in   1  asynchronous, active-low reset
//  frame_tick      in   1  1-cycle pulse per frame (start of vblank)
//  game_start      in   1  1-cycle pulse: begin obstacle sequence
//  game_over       in   1  level/pulse: abort sequence immediately
//  obstacle_done   in   8  per-slot level, bit i = obstacle i finished (bit IDLE_SEL ignored)
//  select          out  3  mux select; IDLE_SEL when no obstacle is active
//  obstacle_start  out  8  one-hot 1-cycle start pulse to the chosen generator
//  active          out  1  high while the sequence runs (LOAD/RUN/GAP)
//  round_count     out  8  obstacles completed since game_start, saturates at 255
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, select=IDLE_SEL, obstacle_start=0, active=0,
//   round_count=0, lfsr=LFSR_SEED, frame_cnt=0, last_sel=IDLE_SEL. All outputs registered.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every cycle when not in reset, including IDLE.
//  States:
//   IDLE: active=0. game_start -> LOAD; round_count<=0 on that edge.
//   LOAD (1 cycle): cand=lfsr[2:0]; if cand==IDLE_SEL, cand=IDLE_SEL+1 (mod 8).
//    If cand==last_sel, step cand by +1 (mod 8), skipping IDLE_SEL.
//    select<=cand, last_sel<=cand, obstacle_start<=1<<cand, frame_cnt<=0 -> RUN.
//   RUN: obstacle_start is high only in the first RUN cycle; obstacle_done is ignored in that cycle.
//    frame_cnt increments on frame_tick.
//    Exit when obstacle_done[select]==1, or when frame_tick and frame_cnt==TIMEOUT_FRAMES-1.
//    On exit: select<=IDLE_SEL, round_count<=sat+1, frame_cnt<=0 -> GAP.
//   GAP: select=IDLE_SEL. frame_cnt increments on frame_tick.
//    When frame_tick and frame_cnt==GAP_FRAMES-1 -> LOAD.
//  Latency: game_start at cycle N -> select valid and obstacle_start pulse at N+2.
//  game_over: highest priority, checked in every state.
//   Next edge: state=IDLE, select=IDLE_SEL, obstacle_start=0, active=0.
//   round_count and last_sel are held until the next game_start.
//  Simultaneous game_start and game_over: game_over wins, stay IDLE.
//  game_start outside IDLE: ignored.
//  Done and timeout in the same cycle: a single exit; round_count increments once.
//  frame_cnt width: clog2(max(GAP_FRAMES,TIMEOUT_FRAMES)). Never wraps; cleared on each state entry.
// STRUCTURE
//  Shared header obstacle_defs.vh:
//   state encodings (IDLE/LOAD/RUN/GAP), SEL_W=3, N_SLOTS=8, OBST_W=36, IDLE_SEL default.
//  Sub-module obstacle_lfsr (8-bit, seed parameter, enable input).
//  FSM, counters and select logic stay in this file.
// TESTING
//  1 Reset released, no game_start for 100 frames -> select=0, active=0, obstacle_start=0 throughout.
//  2 game_start @N -> select!=0 and matching one-hot obstacle_start pulse @N+2.
//    Raise obstacle_done[select] 5 frames later -> next edge select=0.
//    Next obstacle starts after exactly GAP_FRAMES frame_ticks.
//  3 obstacle_done held 0 -> forced exit on the TIMEOUT_FRAMES-th frame_tick; round_count=1.
//  4 Run 300 obstacles with a fixed seed -> select never 0 in RUN, never equal to the previous obstacle.
//    round_count saturates at 255.
//  5 game_over mid-RUN -> next edge IDLE, select=0, round_count held.
//    Later game_start -> round_count=0.
//  6 rst pulsed low mid-GAP (async, no clock edge) -> outputs at reset values immediately.

Source files
------------

// File: rtl/obstacle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_sequencer_pkg
// Shared definitions for the obstacle sequencer: mux geometry, FSM state
// encoding and the slot-selection helper used when loading a new obstacle.
// -----------------------------------------------------------------------------
package obstacle_sequencer_pkg;

    localparam int SEL_W   = 3;   // width of the obstacle mux select
    localparam int N_SLOTS = 8;   // number of mux inputs / generators
    localparam int OBST_W  = 36;  // width of one obstacle bus into the mux
    localparam int LFSR_W  = 8;

    localparam logic [SEL_W-1:0] IDLE_SEL_DEF = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Turn a random 3-bit value into a playable slot: never the idle slot and
    // never the slot used last time. A single +1 step away from last_sel is
    // enough because last_sel itself is never the idle slot.
    function automatic logic [SEL_W-1:0] pick_sel(
        input logic [SEL_W-1:0] rnd,
        input logic [SEL_W-1:0] last_sel,
        input logic [SEL_W-1:0] idle_sel
    );
        logic [SEL_W-1:0] cand;
        cand = rnd;
        if (cand == idle_sel) begin
            cand = cand + 3'd1;
        end
        if (cand == last_sel) begin
            cand = cand + 3'd1;
            if (cand == idle_sel) begin
                cand = cand + 3'd1;
            end
        end
        return cand;
    endfunction

endpackage

// File: rtl/obstacle_sequencer_lfsr.sv
// -----------------------------------------------------------------------------
// obstacle_sequencer_lfsr
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the obstacle randomiser.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (loads SEED)
//   en     in   shift enable
//   rnd    out  low SEL_W bits of the LFSR state
// -----------------------------------------------------------------------------
module obstacle_sequencer_lfsr
    import obstacle_sequencer_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [SEL_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsr_q;
    logic              fb;

    // Taps 8,6,5,4 in 1-based polynomial numbering map to bits 7,5,4,3.
    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    assign rnd = lfsr_q[SEL_W-1:0];

endmodule

// File: rtl/obstacle_sequencer.sv
// -----------------------------------------------------------------------------
// obstacle_sequencer
// Drives the 8:1 obstacle mux select and starts each obstacle generator in
// turn. Picks the next slot pseudo-randomly (never idle, never a repeat),
// waits for that generator's done flag or a frame timeout, holds a blank gap
// and repeats until game_over.
// Ports:
//   pclk            in   pixel clock
//   rst             in   asynchronous active-low reset
//   frame_tick      in   1-cycle pulse per frame
//   game_start      in   1-cycle pulse, begins the sequence from IDLE
//   game_over       in   aborts the sequence on the next edge
//   obstacle_done   in   [7:0] per-slot done levels
//   select          out  [2:0] mux select, IDLE_SEL when no obstacle runs
//   obstacle_start  out  [7:0] one-hot 1-cycle start pulse
//   active          out  high in LOAD/RUN/GAP
//   round_count     out  [7:0] obstacles completed, saturating at 255
// -----------------------------------------------------------------------------
module obstacle_sequencer
    import obstacle_sequencer_pkg::*;
#(
    parameter int               GAP_FRAMES     = 30,
    parameter int               TIMEOUT_FRAMES = 600,
    parameter logic [7:0]       LFSR_SEED      = 8'hA5,
    parameter logic [SEL_W-1:0] IDLE_SEL       = IDLE_SEL_DEF
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               game_start,
    input  logic               game_over,
    input  logic [N_SLOTS-1:0] obstacle_done,
    output logic [SEL_W-1:0]   select,
    output logic [N_SLOTS-1:0] obstacle_start,
    output logic               active,
    output logic [7:0]         round_count
);

    localparam int MAX_FRAMES = (GAP_FRAMES > TIMEOUT_FRAMES) ? GAP_FRAMES : TIMEOUT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_FRAMES - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_sel_q;
    logic [N_SLOTS-1:0] start_q;
    logic               active_q;
    logic [7:0]         round_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [SEL_W-1:0]   rnd;
    logic [SEL_W-1:0]   cand_d;
    logic               first_run;
    logic               done_hit;
    logic               tmo_hit;
    logic               run_exit;
    logic [7:0]         round_d;

    obstacle_sequencer_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (pclk),
        .rst_n (rst),
        .en    (1'b1),
        .rnd   (rnd)
    );

    assign cand_d = pick_sel(rnd, last_sel_q, IDLE_SEL);

    // The start pulse is only ever high in the first RUN cycle, so it doubles
    // as the "ignore done this cycle" flag.
    assign first_run = |start_q;
    assign done_hit  = obstacle_done[sel_q] && !first_run;
    assign tmo_hit   = frame_tick && (cnt_q == TMO_LAST);
    assign run_exit  = done_hit || tmo_hit;
    assign round_d   = (round_q == 8'hFF) ? round_q : round_q + 8'd1;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= IDLE_SEL;
            last_sel_q <= IDLE_SEL;
            start_q    <= '0;
            active_q   <= 1'b0;
            round_q    <= 8'd0;
            cnt_q      <= '0;
        end else begin
            start_q <= '0;
            if (game_over) begin
                // round_q and last_sel_q deliberately keep their values.
                state_q  <= ST_IDLE;
                sel_q    <= IDLE_SEL;
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (game_start) begin
                            state_q  <= ST_LOAD;
                            active_q <= 1'b1;
                            round_q  <= 8'd0;
                        end
                    end
                    ST_LOAD: begin
                        sel_q      <= cand_d;
                        last_sel_q <= cand_d;
                        start_q    <= N_SLOTS'(1) << cand_d;
                        cnt_q      <= '0;
                        state_q    <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (run_exit) begin
                            sel_q   <= IDLE_SEL;
                            round_q <= round_d;
                            cnt_q   <= '0;
                            state_q <= ST_GAP;
                        end else if (frame_tick) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (frame_tick) begin
                            if (cnt_q == GAP_LAST) begin
                                cnt_q   <= '0;
                                state_q <= ST_LOAD;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign select         = sel_q;
    assign obstacle_start = start_q;
    assign active         = active_q;
    assign round_count    = round_q;

endmodule
